// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are latched at accept, held on the ALU for SETTLE_CYCLES, then the result is captured.
module alu_arbiter #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [3:0]       alu_c,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_lt,
  input  logic             alu_eq,
  input  logic             alu_gt,
  input  logic             alu_ovf,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [5:0]       rsp_flags,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens in any cycle where valid && ready are both
  // high at the rising edge. Requester readies are combinational and only ever
  // high in IDLE (at most one at a time); the response is held until rsp_ready.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic       last_grant;
  logic [3:0] settle_cnt;
  logic       op_id;
  logic       grant0;
  logic       grant1;
  logic       legal_op;

  // last_grant == 1 means requester 0 wins the next tie.
  always_comb begin
    grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  end

  always_comb begin
    legal_op = 1'b0;
    case (alu_c)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: legal_op = 1'b1;
      default:                                       legal_op = 1'b0;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      settle_cnt <= 4'd0;
      op_id      <= 1'b0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_c      <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_x      <= grant1 ? req1_a  : req0_a;
            alu_y      <= grant1 ? req1_b  : req0_b;
            alu_c      <= grant1 ? req1_op : req0_op;
            op_id      <= grant1;
            last_grant <= grant1;
            settle_cnt <= CNT_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            // Undefined opcodes report err and ignore whatever the ALU produced.
            if (legal_op) begin
              rsp_result <= alu_z;
              rsp_flags  <= {1'b0, alu_cout, alu_ovf, alu_gt, alu_eq, alu_lt};
            end else begin
              rsp_result <= '0;
              rsp_flags  <= 6'b100000;
            end
            state <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model (busy window, due cycle, round-robin rule, expected queue).
module tb_alu_arbiter;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- instance A (SETTLE_CYCLES = 1) ----------------
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op, alu_c;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_x, alu_y, alu_z, rsp_result;
  logic         alu_lt, alu_eq, alu_gt, alu_ovf, alu_cout;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [5:0]   rsp_flags;
  logic [1:0]   dbg_state;

  // ---------------- instance B (SETTLE_CYCLES = 4) ----------------
  logic         b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [3:0]   b_req0_op, b_req1_op, b_alu_c;
  logic [W-1:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b, b_alu_x, b_alu_y, b_alu_z, b_rsp_result;
  logic         b_alu_lt, b_alu_eq, b_alu_gt, b_alu_ovf, b_alu_cout;
  logic         b_rsp_valid, b_rsp_ready, b_rsp_id;
  logic [5:0]   b_rsp_flags;
  logic [1:0]   b_dbg_state;

  // Behavioural ALU: returns {cout, ovf, gt, eq, lt, z}; unlisted opcodes give junk.
  function automatic logic [20:0] alu_fn(logic [3:0] c, logic [W-1:0] x, logic [W-1:0] y);
    logic [16:0]  s;
    logic [W-1:0] z;
    logic         co, ov;
    co = 1'b0;
    ov = 1'b0;
    z  = x ^ y;
    case (c)
      4'd0: z = x & y;
      4'd1: z = x | y;
      4'd2: begin
        s  = {1'b0, x} + {1'b0, y};
        z  = s[15:0];
        co = s[16];
        ov = (x[15] == y[15]) && (z[15] != x[15]);
      end
      4'd3: begin
        s  = {1'b0, x} + {1'b0, ~y} + 17'd1;
        z  = s[15:0];
        co = s[16];
        ov = (x[15] != y[15]) && (z[15] != x[15]);
      end
      4'd7: z = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      default: ;
    endcase
    return {co, ov, $signed(x) > $signed(y), x == y, $signed(x) < $signed(y), z};
  endfunction

  // Expected response {id, flags[5:0], result}.
  function automatic logic [22:0] exp_rsp(logic id, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    logic [20:0] r;
    r = alu_fn(op, a, b);
    if (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7}) return {id, 1'b0, r[20:16], r[15:0]};
    return {id, 6'b100000, 16'h0000};
  endfunction

  assign {alu_cout, alu_ovf, alu_gt, alu_eq, alu_lt, alu_z} = alu_fn(alu_c, alu_x, alu_y);
  assign {b_alu_cout, b_alu_ovf, b_alu_gt, b_alu_eq, b_alu_lt, b_alu_z} = alu_fn(b_alu_c, b_alu_x, b_alu_y);

  alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z),
    .alu_lt(alu_lt), .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_ovf(alu_ovf), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .dbg_state(dbg_state)
  );

  alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op), .req0_a(b_req0_a), .req0_b(b_req0_b),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op), .req1_a(b_req1_a), .req1_b(b_req1_b),
    .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_c(b_alu_c), .alu_z(b_alu_z),
    .alu_lt(b_alu_lt), .alu_eq(b_alu_eq), .alu_gt(b_alu_gt), .alu_ovf(b_alu_ovf), .alu_cout(b_alu_cout),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
    .rsp_result(b_rsp_result), .rsp_flags(b_rsp_flags), .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [22:0]  exp_q[$];
  int           glog[$];
  int           gtime[$];
  int           t = 0;
  bit           busy = 1'b0;
  int           due = 0;
  bit           last = 1'b1;
  logic [3:0]   cur_op;
  logic [W-1:0] cur_a, cur_b;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of instance A: called with inputs already driven at posedge+1.
  task automatic cycle_a();
    logic e0, e1, ev;
    #1;
    e0 = !busy && req0_valid && (!req1_valid || last);
    e1 = !busy && req1_valid && (!req0_valid || !last);
    ev = busy && (t >= due);
    check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
    if (ev && exp_q.size() > 0)
      check("rsp_payload", {9'd0, rsp_id, rsp_flags, rsp_result}, {9'd0, exp_q[0]});
    if (busy && t < due)
      check("alu_inputs", {alu_c, 12'd0, alu_x}, {cur_op, 12'd0, cur_a});
    if (busy && t < due)
      check("alu_y", {16'd0, alu_y}, {16'd0, cur_b});
    if (!reset && req0_valid && req0_ready) begin glog.push_back(0); gtime.push_back(t); end
    if (!reset && req1_valid && req1_ready) begin glog.push_back(1); gtime.push_back(t); end
    if (reset) begin
      busy = 1'b0;
      last = 1'b1;
      exp_q.delete();
    end else if (ev && rsp_ready) begin
      busy = 1'b0;
      void'(exp_q.pop_front());
    end else if (e0 || e1) begin
      busy   = 1'b1;
      due    = t + 2;
      last   = e1;
      cur_op = e1 ? req1_op : req0_op;
      cur_a  = e1 ? req1_a  : req0_a;
      cur_b  = e1 ? req1_b  : req0_b;
      exp_q.push_back(exp_rsp(e1, cur_op, cur_a, cur_b));
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle_a();
  endtask

  task automatic drive0(logic v, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(logic v, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    rsp_ready = 1'b0;
    {b_req0_valid, b_req0_op, b_req0_a, b_req0_b} = '0;
    {b_req1_valid, b_req1_op, b_req1_a, b_req1_b} = '0;
    b_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    check("reset_alu_x", {16'd0, alu_x}, 32'd0);
    check("reset_alu_y", {16'd0, alu_y}, 32'd0);
    check("reset_alu_c", {28'd0, alu_c}, 32'd0);
    check("reset_rsp", {6'd0, rsp_valid, rsp_id, rsp_flags, rsp_result}, 32'd0);
    check("reset_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("reset_b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);

    // SETTLE_CYCLES=4: slt 3<9, operands held 4 cycles, response at T+5
    b_req0_valid = 1'b1; b_req0_op = 4'd7; b_req0_a = 16'd3; b_req0_b = 16'd9;
    #1;
    check("b_accept", {31'd0, b_req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    b_req0_valid = 1'b0; b_req0_op = 4'd2; b_req0_a = 16'hDEAD; b_req0_b = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      check("b_hold_x", {16'd0, b_alu_x}, 32'd3);
      check("b_hold_y", {16'd0, b_alu_y}, 32'd9);
      check("b_hold_c", {28'd0, b_alu_c}, 32'd7);
      check("b_no_rsp_yet", {31'd0, b_rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    check("b_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
    check("b_rsp", {9'd0, b_rsp_id, b_rsp_flags, b_rsp_result}, {9'd0, 1'b0, 6'b000001, 16'h0001});
    b_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("b_rsp_drop", {31'd0, b_rsp_valid}, 32'd0);

    // Single add on instance A
    rsp_ready = 1'b1;
    drive0(1, 4'b0010, 16'h00E0, 16'h0007);
    cycle_a();
    drive0(0, 4'b0010, 16'h1111, 16'h2222);
    cycle_a();
    check("add_valid", {31'd0, rsp_valid}, 32'd1);
    check("add_rsp", {9'd0, rsp_id, rsp_flags[5], rsp_result}, {9'd0, 1'b0, 1'b0, 16'h00E7});
    run(2);

    // Tie after reset: grants 0,1,0,1 spaced 3 cycles
    reset = 1'b1;
    cycle_a();
    reset = 1'b0;
    glog.delete();
    gtime.delete();
    drive0(1, 4'b0010, 16'd1, 16'd1);
    drive1(1, 4'b0011, 16'd5, 16'd3);
    run(11);
    check("tie_count", glog.size(), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      check("tie_grant", glog[i], i % 2);
    for (int i = 0; i + 1 < 4 && i + 1 < gtime.size(); i++)
      check("tie_spacing", gtime[i+1] - gtime[i], 32'd3);
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    run(4);

    // Backpressure: response held 5 cycles, requester 1 waits
    drive0(1, 4'b0010, 16'd10, 16'd20);
    rsp_ready = 1'b0;
    cycle_a();
    drive0(0, 0, 0, 0);
    drive1(1, 4'b0011, 16'd7, 16'd2);
    run(1);
    check("bp_result", {16'd0, rsp_result}, 32'd30);
    run(5);
    rsp_ready = 1'b1;
    run(2);
    drive1(0, 0, 0, 0);
    run(4);

    // Illegal opcode from requester 1
    drive1(1, 4'b0100, 16'hFFFF, 16'h0001);
    cycle_a();
    drive1(0, 0, 0, 0);
    cycle_a();
    check("illegal_rsp", {9'd0, rsp_id, rsp_flags, rsp_result}, {9'd0, 1'b1, 6'b100000, 16'h0000});
    run(2);

    // Reset during SETTLE drops the op; next tie goes to requester 0
    drive1(1, 4'b0001, 16'h00F0, 16'h000F);
    cycle_a();
    drive1(0, 0, 0, 0);
    reset = 1'b1;
    cycle_a();
    reset = 1'b0;
    run(4);
    glog.delete();
    drive0(1, 4'b0000, 16'h0F0F, 16'h00FF);
    drive1(1, 4'b0010, 16'h0001, 16'h0002);
    cycle_a();
    check("post_reset_tie", glog.size() > 0 ? glog[0] : -1, 32'd0);
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    run(3);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive0($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      drive1($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        req0_op = ($urandom_range(0, 1) != 0) ? 4'd2 : 4'd3;
        req1_op = ($urandom_range(0, 1) != 0) ? 4'd7 : 4'($urandom_range(0, 1));
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 79) == 0;
      cycle_a();
    end
    reset = 1'b0;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    rsp_ready = 1'b1;
    run(6);
    check("drain_empty", exp_q.size(), 32'd0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
